lock_requester: RTL and testbench

LOCK_REQUESTER -- requirements
Module: lock_requester

---
 rtl/lock_requester.sv | 185 ++++++++++++++++++
 tb/tb_lock_requester.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/lock_requester.sv
// Lock requester: requests a lock, retries with backoff on timeout, holds it
// for a programmed number of cycles, then releases it and reports the outcome.
`timescale 1ns/1ps

module lock_requester #(
  parameter int HOLD_W    = 8,
  parameter int TIMEOUT   = 16,
  parameter int MAX_RETRY = 3,
  parameter int BACKOFF   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [HOLD_W-1:0] hold_cycles,
  input  logic              locked,
  output logic              lock_req,
  output logic              unlock,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic              lock_lost
);

  localparam int WAIT_W  = $clog2(TIMEOUT);
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int BO_W    = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;

  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [BO_W-1:0]    BO_LAST   = BO_W'(BACKOFF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_BACKOFF,
    S_HOLD,
    S_REL
  } state_t;

  state_t              r_state;
  logic [WAIT_W-1:0]   r_wait;
  logic [RETRY_W-1:0]  r_retry;
  logic [BO_W-1:0]     r_bo;
  logic [HOLD_W-1:0]   r_hold_cap;
  logic [HOLD_W-1:0]   r_hold_cnt;

  logic                r_lock_req;
  logic                r_unlock;
  logic                r_busy;
  logic                r_done;
  logic                r_timeout_err;
  logic                r_lock_lost;

  state_t              w_state_nxt;
  logic [WAIT_W-1:0]   w_wait_nxt;
  logic [RETRY_W-1:0]  w_retry_nxt;
  logic [BO_W-1:0]     w_bo_nxt;
  logic [HOLD_W-1:0]   w_hold_cap_nxt;
  logic [HOLD_W-1:0]   w_hold_cnt_nxt;
  logic                w_done_nxt;
  logic                w_timeout_nxt;
  logic                w_lost_nxt;

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_nxt     = r_wait;
    w_retry_nxt    = r_retry;
    w_bo_nxt       = r_bo;
    w_hold_cap_nxt = r_hold_cap;
    w_hold_cnt_nxt = r_hold_cnt;
    w_done_nxt     = 1'b0;
    w_timeout_nxt  = 1'b0;
    w_lost_nxt     = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_hold_cap_nxt = hold_cycles;
          w_retry_nxt    = '0;
          w_wait_nxt     = '0;
          w_bo_nxt       = '0;
          w_state_nxt    = S_REQ;
        end
      end

      S_REQ: begin
        // A grant on the last wait cycle still wins over the timeout.
        if (locked) begin
          w_hold_cnt_nxt = r_hold_cap;
          w_state_nxt    = S_HOLD;
        end else if (r_wait == WAIT_LAST) begin
          if (r_retry < RETRY_MAX) begin
            w_retry_nxt = r_retry + RETRY_W'(1);
            w_bo_nxt    = '0;
            w_state_nxt = S_BACKOFF;
          end else begin
            w_timeout_nxt = 1'b1;
            w_state_nxt   = S_IDLE;
          end
        end else begin
          w_wait_nxt = r_wait + WAIT_W'(1);
        end
      end

      S_BACKOFF: begin
        if (r_bo == BO_LAST) begin
          w_wait_nxt  = '0;
          w_state_nxt = S_REQ;
        end else begin
          w_bo_nxt = r_bo + BO_W'(1);
        end
      end

      S_HOLD: begin
        // Losing the lock beats hold expiry and skips the release handshake.
        if (!locked) begin
          w_lost_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_hold_cnt == '0) begin
          w_state_nxt = S_REL;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt - HOLD_W'(1);
        end
      end

      S_REL: begin
        if (!locked) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wait     <= '0;
      r_retry    <= '0;
      r_bo       <= '0;
      r_hold_cap <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait     <= w_wait_nxt;
      r_retry    <= w_retry_nxt;
      r_bo       <= w_bo_nxt;
      r_hold_cap <= w_hold_cap_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

  // Outputs decode the next state so they line up with the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_req    <= 1'b0;
      r_unlock      <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_lock_lost   <= 1'b0;
    end else begin
      r_lock_req    <= (w_state_nxt == S_REQ);
      r_unlock      <= (w_state_nxt == S_REL);
      r_busy        <= (w_state_nxt != S_IDLE);
      r_done        <= w_done_nxt;
      r_timeout_err <= w_timeout_nxt;
      r_lock_lost   <= w_lost_nxt;
    end
  end

  assign lock_req    = r_lock_req;
  assign unlock      = r_unlock;
  assign busy        = r_busy;
  assign done        = r_done;
  assign timeout_err = r_timeout_err;
  assign lock_lost   = r_lock_lost;

endmodule

// File: tb/tb_lock_requester.sv
// Bench for lock_requester: a reactive lock-controller model drives locked,
// a transaction-level model predicts each outcome, a monitor checks it.
`timescale 1ns/1ps

module tb_lock_requester;

  localparam int HOLD_W    = 8;
  localparam int TIMEOUT   = 16;
  localparam int MAX_RETRY = 3;
  localparam int BACKOFF   = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [HOLD_W-1:0] hold_cycles = '0;
  logic              locked = 1'b0;
  logic              lock_req, unlock, busy, done, timeout_err, lock_lost;

  lock_requester #(
    .HOLD_W(HOLD_W), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY), .BACKOFF(BACKOFF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hold_cycles(hold_cycles),
    .locked(locked), .lock_req(lock_req), .unlock(unlock), .busy(busy),
    .done(done), .timeout_err(timeout_err), .lock_lost(lock_lost)
  );

  always #5 clk = ~clk;

  // outc = {done, timeout_err, lock_lost}
  typedef struct {
    logic [2:0] outc;
    int         win;
    int         req;
    int         gap;
    int         unl;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_flush = 1'b0;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Outcome of one transaction from the behavioural rules: ga = attempt that
  // is granted (0 = never), d = wait count at grant, r = cycles until release.
  function automatic exp_t model(input int h, input int ga, input int d,
                                 input bit lost, input int lost_at, input int r);
    exp_t e;
    if (ga == 0) begin
      e.outc = 3'b010;
      e.win  = MAX_RETRY + 1;
      e.req  = (MAX_RETRY + 1) * TIMEOUT;
      e.gap  = MAX_RETRY * BACKOFF;
      e.unl  = 0;
    end else begin
      e.win = ga;
      e.req = (ga - 1) * TIMEOUT + d + 1;
      if (lost && lost_at <= h) begin
        e.outc = 3'b001;
        e.gap  = (ga - 1) * BACKOFF + lost_at + 1;
        e.unl  = 0;
      end else begin
        e.outc = 3'b100;
        e.gap  = (ga - 1) * BACKOFF + h + 1;
        e.unl  = r + 1;
      end
    end
    return e;
  endfunction

  // Monitor: accumulate per-transaction activity, compare on each end pulse.
  int   m_win, m_req, m_gap, m_unl, m_both;
  bit   m_prev_req;
  exp_t m_e;

  task automatic mon_clear();
    m_win = 0; m_req = 0; m_gap = 0; m_unl = 0; m_both = 0; m_prev_req = 1'b0;
  endtask

  initial begin
    mon_clear();
    forever begin
      @(posedge clk); #1;
      if (mon_flush) begin
        mon_clear();
        mon_flush = 1'b0;
      end
      if (lock_req && !m_prev_req) m_win++;
      if (lock_req) m_req++;
      if (unlock) m_unl++;
      if (busy && !lock_req && !unlock) m_gap++;
      if (lock_req && unlock) m_both++;
      m_prev_req = lock_req;
      if (done || timeout_err || lock_lost) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", int'({done, timeout_err, lock_lost}), 0);
        end else begin
          m_e = exp_q.pop_front();
          check("outcome", int'({done, timeout_err, lock_lost}), int'(m_e.outc));
          check("req_windows", m_win, m_e.win);
          check("req_cycles", m_req, m_e.req);
          check("gap_cycles", m_gap, m_e.gap);
          check("unlock_cycles", m_unl, m_e.unl);
          check("busy_at_end", int'(busy), 0);
          check("req_unlock_overlap", m_both, 0);
        end
        mon_clear();
      end
    end
  end

  // One transaction with the lock controller reacting to the DUT's outputs.
  task automatic run_txn(input int h, input int ga, input int d, input bit lost,
                         input int lost_at, input int r, input bit rst_rel);
    int att = 0;
    int k = 0;
    int hc = 0;
    int u = 0;
    bit prev = 1'b0;
    bit fin = 1'b0;
    start = 1'b1;
    hold_cycles = HOLD_W'(h);
    locked = 1'b0;
    if (!rst_rel) exp_q.push_back(model(h, ga, d, lost, lost_at, r));
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 0) check("start_accept", int'(busy && lock_req), 1);
      if (!busy) begin
        start = 1'b0;
        fin = 1'b1;
      end else begin
        start = 1'($urandom_range(0, 1));
        hold_cycles = HOLD_W'($urandom);
        if (lock_req) begin
          if (!prev) begin
            att++;
            k = 0;
          end else begin
            k++;
          end
          if (att == ga && k == d) locked = 1'b1;
        end else if (unlock) begin
          if (rst_rel) begin
            rst_n = 1'b0;
            #1;
            check("rst_lock_req", int'(lock_req), 0);
            check("rst_unlock", int'(unlock), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_pulses", int'({done, timeout_err, lock_lost}), 0);
            locked = 1'b0;
            start = 1'b0;
            exp_q.delete();
            mon_flush = 1'b1;
            @(negedge clk);
            check("rst_held_busy", int'(busy), 0);
            rst_n = 1'b1;
            fin = 1'b1;
          end else begin
            if (u == r) locked = 1'b0;
            u++;
          end
        end else if (locked) begin
          if (lost && hc == lost_at) locked = 1'b0;
          hc++;
        end
        prev = lock_req;
      end
    end
    if (!fin) check("txn_cycle_budget", 0, 1);
  endtask

  initial begin
    int h, ga, d, lost_at, r;
    bit lost;
    rst_n = 1'b0;
    #12;
    check("reset_lock_req", int'(lock_req), 0);
    check("reset_unlock", int'(unlock), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_timeout_err", int'(timeout_err), 0);
    check("reset_lock_lost", int'(lock_lost), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_txn(3, 1, 2, 1'b0, 0, 1, 1'b0);                      // nominal
    run_txn(2, 0, 0, 1'b0, 0, 0, 1'b0);                      // all attempts time out
    run_txn(4, 2, 7, 1'b0, 0, 2, 1'b0);                      // grant on 2nd attempt
    run_txn(1, 1, TIMEOUT - 1, 1'b0, 0, 0, 1'b0);            // grant at expiry
    run_txn(0, MAX_RETRY + 1, TIMEOUT - 1, 1'b0, 0, 0, 1'b0); // last attempt, at expiry
    run_txn(0, 1, 0, 1'b0, 0, 0, 1'b0);                      // zero hold
    run_txn(5, 1, 3, 1'b1, 2, 0, 1'b0);                      // lock lost mid-hold
    run_txn(3, 1, 1, 1'b1, 3, 0, 1'b0);                      // lock lost on final hold cycle
    run_txn(2, 1, 1, 1'b0, 0, 3, 1'b1);                      // reset while releasing
    run_txn(3, 1, 2, 1'b0, 0, 1, 1'b0);                      // clean run after reset

    repeat (60) begin
      case ($urandom_range(0, 3))
        0:       h = 0;
        1:       h = $urandom_range(1, 4);
        2:       h = $urandom_range(5, 40);
        default: h = ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 10);
      endcase
      ga = $urandom_range(0, MAX_RETRY + 1);
      d = ($urandom_range(0, 3) == 0) ? TIMEOUT - 1 : $urandom_range(0, TIMEOUT - 1);
      lost = ($urandom_range(0, 3) == 0);
      lost_at = $urandom_range(0, h + 2);
      r = $urandom_range(0, 5);
      run_txn(h, ga, d, lost, lost_at, r, 1'b0);
    end

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
